regfile_alu_datapath: RTL and testbench
=======================================

Name: regfile_alu_datapath

Overview:
Parametrised successor of the two-register 4-bit add/sub datapath. It holds NUM_REGS general registers of WIDTH bits and two operand buses, each sourced from the external input, zero, or any register. The ALU covers ADD/SUB/AND/OR/XOR/PASS plus an iterative multi-cycle MUL. Commands arrive over a valid/ready handshake; completion is a one-cycle done pulse with carry/zero flags. A debug read port feeds the board-level 7-segment decoders.

Parameters:
WIDTH, 4, datapath and register width (>=2)
NUM_REGS, 2, number of general registers (>=2)
IDX_W, max(1,$clog2(NUM_REGS)), derived; register index width
SEL_W, $clog2(NUM_REGS+2), derived; operand-select width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept; high iff FSM in IDLE
cmd_op  in  3  opcode (see Behaviour)
cmd_a_sel  in  SEL_W  operand A source
cmd_b_sel  in  SEL_W  operand B source
cmd_dst  in  IDX_W  destination register
cmd_wr_en  in  1  1 = write result to cmd_dst
x_in  in  WIDTH  external data operand
done_valid  out  1  one-cycle pulse: command completed
result  out  WIDTH  last completed result, held until next completion
flag_c  out  1  carry/borrow of last completion
flag_z  out  1  result==0 of last completion
rd_idx  in  IDX_W  debug read index
rd_data  out  WIDTH  combinational read of reg[rd_idx]; 0 if rd_idx>=NUM_REGS

Behaviour:
- Reset (rst_n low, async): all registers 0, result 0, flag_c 0, flag_z 0, done_valid 0, FSM to IDLE (cmd_ready=1). Reset mid-MUL aborts the command: no write and no done.
- Select codes: 0 = x_in, 1 = constant 0, 2..NUM_REGS+1 = reg[sel-2]; any other code reads 0.
- Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 PASS A, 110 MUL (low WIDTH bits of A*B, unsigned), 111 NOP.
- Accept on the rising edge with cmd_valid&&cmd_ready (edge k). Operands, op, dst and wr_en are captured at k; later changes to x_in or registers do not affect the command.
- Single-cycle ops (ADD..PASS): at edge k write reg[cmd_dst] if wr_en and dst<NUM_REGS, update result and flags, and set done_valid=1 for the cycle after k. cmd_ready stays 1, so back-to-back commands are allowed, and a command accepted at k+1 reads the value written at k.
- MUL: at k the FSM goes IDLE->MUL, cmd_ready=0, and the shift-add counter loads WIDTH. One iteration runs per edge at k+1..k+WIDTH. At edge k+WIDTH: writeback, result/flags update, done_valid=1 for the following cycle, FSM to IDLE. cmd_valid is ignored while busy.
- NOP: done_valid pulses; registers, result and flags are unchanged.
- Flags: ADD C = carry out of bit WIDTH-1; SUB C = borrow (A<B unsigned); all other ops C=0. Z = (result==0).
- Arithmetic wraps modulo 2^WIDTH.
- wr_en=0: result and flags still update, no register write.

Decomposition:
- Package regfile_alu_pkg: opcode localparams (OP_ADD..OP_NOP), select constants (SEL_X=0, SEL_ZERO=1, SEL_REG_BASE=2), FSM state encoding (ST_IDLE, ST_MUL).
- Sub-module seq_mul: WIDTH-parametrised iterative shift-add multiplier with start/done. The combinational ALU, operand muxes and register file stay in the top.

Test Plan (WIDTH=4, NUM_REGS=2):
1. Reset, then ADD a=SEL_X(x_in=5), b=SEL_ZERO, dst=0, wr_en=1 -> reg0=5, result=5, C=0, Z=0, done_valid high exactly 1 cycle; rd_idx=0 gives rd_data=5.
2. reg0=9, ADD a=reg0, b=x_in=8 -> result=1, C=1, Z=0. Back-to-back next cycle PASS a=reg0 -> result=1 (sees new value).
3. SUB 3-5 -> result=0xE, C=1. Then SUB 5-5 -> result=0, C=0, Z=1.
4. reg0=3, MUL a=reg0, b=x_in=6, dst=1 -> cmd_ready low 4 cycles. reg1=2 (18 mod 16), C=0, done one cycle after edge k+4. x_in changed to 0 and cmd_valid held high during busy -> no effect, no extra accept.
5. MUL started, rst_n pulsed low at iteration 2 -> immediate reset values, no done after release, cmd_ready=1, reg1=0.
6. NOP after ADD producing C=1 -> done pulses, result/flags/registers unchanged. ADD with wr_en=0 -> result updates, reg untouched.

Source files
------------

// File: rtl/regfile_alu_pkg.sv
// regfile_alu_pkg: shared opcodes, operand-select codes and FSM encoding for regfile_alu_datapath
package regfile_alu_pkg;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_PASS = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;
  localparam int SEL_X        = 0;
  localparam int SEL_ZERO     = 1;
  localparam int SEL_REG_BASE = 2;
  typedef enum logic {ST_IDLE, ST_MUL} state_t;
endpackage

// File: rtl/regfile_alu_datapath_if.sv
// regfile_alu_datapath_if: command/completion/debug bus of the register-file ALU datapath
// master drives cmd_*, x_in, rd_idx; slave returns cmd_ready, done_valid, result, flags, rd_data
interface regfile_alu_datapath_if #(
  parameter int WIDTH    = 4,
  parameter int NUM_REGS = 2
);
  localparam int IDX_W = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SEL_W = $clog2(NUM_REGS + 2);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [SEL_W-1:0] cmd_a_sel;
  logic [SEL_W-1:0] cmd_b_sel;
  logic [IDX_W-1:0] cmd_dst;
  logic             cmd_wr_en;
  logic [WIDTH-1:0] x_in;
  logic             done_valid;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_z;
  logic [IDX_W-1:0] rd_idx;
  logic [WIDTH-1:0] rd_data;
  modport master (
    output cmd_valid, cmd_op, cmd_a_sel, cmd_b_sel, cmd_dst, cmd_wr_en, x_in, rd_idx,
    input  cmd_ready, done_valid, result, flag_c, flag_z, rd_data
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a_sel, cmd_b_sel, cmd_dst, cmd_wr_en, x_in, rd_idx,
    output cmd_ready, done_valid, result, flag_c, flag_z, rd_data
  );
endinterface

// File: rtl/seq_mul.sv
// seq_mul: iterative shift-add multiplier, low WIDTH bits of i_a*i_b, WIDTH iterations after i_start
// ports: clk, rst_n (async low), i_start loads operands, o_last high during the final iteration,
//        o_prod is the product as it will stand after the current iteration
module seq_mul #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_prod
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc, r_mc, r_mp;
  logic [WIDTH-1:0] w_next;
  assign w_next = r_acc + (r_mp[0] ? r_mc : '0);
  assign o_last = r_cnt == CW'(1);
  // exposing the in-flight sum lets the owner write back on the last iteration edge
  assign o_prod = w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_mc  <= '0;
      r_mp  <= '0;
    end else if (i_start) begin
      r_cnt <= CW'(WIDTH);
      r_acc <= '0;
      r_mc  <= i_a;
      r_mp  <= i_b;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      r_acc <= w_next;
      r_mc  <= r_mc << 1;
      r_mp  <= r_mp >> 1;
    end
  end
endmodule

// File: rtl/regfile_alu_datapath.sv
// regfile_alu_datapath: NUM_REGS x WIDTH register file with muxed operands, single-cycle ALU and iterative MUL
// ports: clk, rst_n (async low), bus (slave): valid/ready command in, done pulse + result/flags out,
//        combinational debug read rd_idx -> rd_data
module regfile_alu_datapath
  import regfile_alu_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int NUM_REGS = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_alu_datapath_if.slave bus
);
  localparam int IDX_W = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SEL_W = $clog2(NUM_REGS + 2);
  logic [NUM_REGS-1:0][WIDTH-1:0] r_regs;
  state_t           r_state, w_next_state;
  logic [IDX_W-1:0] r_dst;
  logic             r_wr_en;
  logic             r_done, r_c, r_z;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_a, w_b, w_rd, w_prod, w_fin_res;
  logic [WIDTH:0]   w_alu;
  logic [IDX_W-1:0] w_fin_dst;
  logic             w_ready, w_acc, w_start, w_single, w_mul_last, w_mul_fin, w_fin, w_fin_we, w_fin_c;
  // unknown select codes fall through to zero
  function automatic logic [WIDTH-1:0] pick(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] x,
                                            input logic [NUM_REGS-1:0][WIDTH-1:0] rf);
    pick = (s == SEL_W'(SEL_X)) ? x : '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (s == SEL_W'(i + SEL_REG_BASE)) pick = rf[i];
  endfunction
  assign w_a = pick(bus.cmd_a_sel, bus.x_in, r_regs);
  assign w_b = pick(bus.cmd_b_sel, bus.x_in, r_regs);
  always_comb begin
    w_alu = '0;
    case (bus.cmd_op)
      OP_ADD:  w_alu = {1'b0, w_a} + {1'b0, w_b};
      OP_SUB:  w_alu = {1'b0, w_a} - {1'b0, w_b};
      OP_AND:  w_alu = {1'b0, w_a & w_b};
      OP_OR:   w_alu = {1'b0, w_a | w_b};
      OP_XOR:  w_alu = {1'b0, w_a ^ w_b};
      OP_PASS: w_alu = {1'b0, w_a};
      default: w_alu = '0;
    endcase
  end
  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_last  (w_mul_last),
    .o_prod  (w_prod)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end
  always_comb begin
    w_next_state = (r_state == ST_IDLE) ? (w_start ? ST_MUL : ST_IDLE)
                                        : (w_mul_last ? ST_IDLE : ST_MUL);
  end
  always_comb begin
    w_ready   = r_state == ST_IDLE;
    w_mul_fin = (r_state == ST_MUL) && w_mul_last;
  end
  assign w_acc     = bus.cmd_valid && w_ready;
  assign w_start   = w_acc && bus.cmd_op == OP_MUL;
  assign w_single  = w_acc && bus.cmd_op != OP_MUL && bus.cmd_op != OP_NOP;
  assign w_fin     = w_single || w_mul_fin;
  assign w_fin_res = w_mul_fin ? w_prod : w_alu[WIDTH-1:0];
  assign w_fin_c   = !w_mul_fin && w_alu[WIDTH];
  assign w_fin_we  = w_mul_fin ? r_wr_en : bus.cmd_wr_en;
  assign w_fin_dst = w_mul_fin ? r_dst : bus.cmd_dst;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs   <= '0;
      r_dst    <= '0;
      r_wr_en  <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      r_done <= (w_acc && !w_start) || w_mul_fin;
      if (w_start) begin
        r_dst   <= bus.cmd_dst;
        r_wr_en <= bus.cmd_wr_en;
      end
      if (w_fin) begin
        r_result <= w_fin_res;
        r_c      <= w_fin_c;
        r_z      <= w_fin_res == '0;
        // out-of-range destinations match no entry and are dropped
        for (int i = 0; i < NUM_REGS; i++)
          if (w_fin_we && w_fin_dst == IDX_W'(i)) r_regs[i] <= w_fin_res;
      end
    end
  end
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus.rd_idx == IDX_W'(i)) w_rd = r_regs[i];
  end
  assign bus.cmd_ready  = w_ready;
  assign bus.done_valid = r_done;
  assign bus.result     = r_result;
  assign bus.flag_c     = r_c;
  assign bus.flag_z     = r_z;
  assign bus.rd_data    = w_rd;
endmodule

// File: tb/tb_regfile_alu_datapath.sv
// tb_regfile_alu_datapath: directed checks of regfile_alu_datapath at WIDTH=4, NUM_REGS=2
module tb_regfile_alu_datapath;
  import regfile_alu_pkg::*;
  localparam logic [1:0] SX = 2'd0, SZ = 2'd1, SR0 = 2'd2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  regfile_alu_datapath_if #(.WIDTH(4), .NUM_REGS(2)) bus ();
  regfile_alu_datapath #(.WIDTH(4), .NUM_REGS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic cmd(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                     input logic dst, input logic we, input logic [3:0] x);
    bus.cmd_op = op; bus.cmd_a_sel = a; bus.cmd_b_sel = b;
    bus.cmd_dst = dst; bus.cmd_wr_en = we; bus.x_in = x; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask
  task automatic test_reset;
    bus.cmd_valid = 0; bus.cmd_op = OP_NOP; bus.cmd_a_sel = SX; bus.cmd_b_sel = SZ;
    bus.cmd_dst = 0; bus.cmd_wr_en = 0; bus.x_in = 0; bus.rd_idx = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.cmd_ready); end
    checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done_valid); end
    checks++; if (bus.result !== 4'h0) begin errors++; $display("FAIL rst_result: got %h want 0", bus.result); end
    checks++; if ({bus.flag_c, bus.flag_z} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {bus.flag_c, bus.flag_z}); end
    checks++; if (bus.rd_data !== 4'h0) begin errors++; $display("FAIL rst_reg0: got %h want 0", bus.rd_data); end
    bus.rd_idx = 1; #1;
    checks++; if (bus.rd_data !== 4'h0) begin errors++; $display("FAIL rst_reg1: got %h want 0", bus.rd_data); end
    rst_n = 1;
  endtask
  task automatic test_add_basic;
    cmd(OP_ADD, SX, SZ, 0, 1, 4'd5);
    checks++; if (bus.done_valid !== 1'b1) begin errors++; $display("FAIL add_done: got %b want 1", bus.done_valid); end
    checks++; if (bus.result !== 4'h5) begin errors++; $display("FAIL add_result: got %h want 5", bus.result); end
    checks++; if ({bus.flag_c, bus.flag_z} !== 2'b00) begin errors++; $display("FAIL add_flags: got %b want 00", {bus.flag_c, bus.flag_z}); end
    bus.rd_idx = 0; #1;
    checks++; if (bus.rd_data !== 4'h5) begin errors++; $display("FAIL add_reg0: got %h want 5", bus.rd_data); end
    @(posedge clk); #1;
    checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL add_done_width: got %b want 0", bus.done_valid); end
  endtask
  task automatic test_back_to_back;
    cmd(OP_ADD, SX, SZ, 0, 1, 4'd9);
    cmd(OP_ADD, SR0, SX, 0, 1, 4'd8);
    checks++; if (bus.result !== 4'h1) begin errors++; $display("FAIL carry_result: got %h want 1", bus.result); end
    checks++; if ({bus.flag_c, bus.flag_z} !== 2'b10) begin errors++; $display("FAIL carry_flags: got %b want 10", {bus.flag_c, bus.flag_z}); end
    cmd(OP_PASS, SR0, SZ, 1, 1, 4'd0);
    checks++; if (bus.done_valid !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", bus.done_valid); end
    checks++; if (bus.result !== 4'h1) begin errors++; $display("FAIL b2b_pass: got %h want 1", bus.result); end
    checks++; if (bus.flag_c !== 1'b0) begin errors++; $display("FAIL b2b_c: got %b want 0", bus.flag_c); end
    bus.rd_idx = 1; #1;
    checks++; if (bus.rd_data !== 4'h1) begin errors++; $display("FAIL b2b_reg1: got %h want 1", bus.rd_data); end
  endtask
  task automatic test_sub;
    cmd(OP_ADD, SX, SZ, 0, 1, 4'd3);
    cmd(OP_SUB, SR0, SX, 0, 0, 4'd5);
    checks++; if (bus.result !== 4'hE) begin errors++; $display("FAIL sub_borrow_result: got %h want e", bus.result); end
    checks++; if ({bus.flag_c, bus.flag_z} !== 2'b10) begin errors++; $display("FAIL sub_borrow_flags: got %b want 10", {bus.flag_c, bus.flag_z}); end
    bus.rd_idx = 0; #1;
    checks++; if (bus.rd_data !== 4'h3) begin errors++; $display("FAIL sub_noreg: got %h want 3", bus.rd_data); end
    cmd(OP_SUB, SX, SX, 0, 0, 4'd5);
    checks++; if (bus.result !== 4'h0) begin errors++; $display("FAIL sub_zero_result: got %h want 0", bus.result); end
    checks++; if ({bus.flag_c, bus.flag_z} !== 2'b01) begin errors++; $display("FAIL sub_zero_flags: got %b want 01", {bus.flag_c, bus.flag_z}); end
  endtask
  task automatic test_mul;
    cmd(OP_ADD, SX, SZ, 0, 1, 4'd3);
    bus.cmd_op = OP_MUL; bus.cmd_a_sel = SR0; bus.cmd_b_sel = SX;
    bus.cmd_dst = 1; bus.cmd_wr_en = 1; bus.x_in = 4'd6; bus.cmd_valid = 1;
    @(posedge clk); #1;
    bus.x_in = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++; if ({bus.cmd_ready, bus.done_valid} !== 2'b00) begin errors++; $display("FAIL mul_busy%0d: got ready,done=%b want 00", i, {bus.cmd_ready, bus.done_valid}); end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    checks++; if ({bus.cmd_ready, bus.done_valid} !== 2'b11) begin errors++; $display("FAIL mul_done: got ready,done=%b want 11", {bus.cmd_ready, bus.done_valid}); end
    checks++; if (bus.result !== 4'h2) begin errors++; $display("FAIL mul_result: got %h want 2", bus.result); end
    checks++; if ({bus.flag_c, bus.flag_z} !== 2'b00) begin errors++; $display("FAIL mul_flags: got %b want 00", {bus.flag_c, bus.flag_z}); end
    bus.rd_idx = 1; #1;
    checks++; if (bus.rd_data !== 4'h2) begin errors++; $display("FAIL mul_reg1: got %h want 2", bus.rd_data); end
    @(posedge clk); #1;
    checks++; if ({bus.cmd_ready, bus.done_valid} !== 2'b10) begin errors++; $display("FAIL mul_no_reaccept: got ready,done=%b want 10", {bus.cmd_ready, bus.done_valid}); end
  endtask
  task automatic test_mul_reset;
    int dones;
    dones = 0;
    cmd(OP_MUL, SR0, SX, 1, 1, 4'd6);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 0; #1;
    checks++; if ({bus.cmd_ready, bus.done_valid} !== 2'b10) begin errors++; $display("FAIL mrst_ready_done: got %b want 10", {bus.cmd_ready, bus.done_valid}); end
    checks++; if (bus.result !== 4'h0) begin errors++; $display("FAIL mrst_result: got %h want 0", bus.result); end
    bus.rd_idx = 1; #1;
    checks++; if (bus.rd_data !== 4'h0) begin errors++; $display("FAIL mrst_reg1: got %h want 0", bus.rd_data); end
    #2 rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done_valid === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL mrst_no_done: got %0d pulses want 0", dones); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready_after: got %b want 1", bus.cmd_ready); end
    checks++; if (bus.rd_data !== 4'h0) begin errors++; $display("FAIL mrst_reg1_after: got %h want 0", bus.rd_data); end
  endtask
  task automatic test_nop_wr_en;
    cmd(OP_ADD, SX, SZ, 0, 1, 4'd9);
    cmd(OP_ADD, SR0, SX, 1, 1, 4'd8);
    cmd(OP_NOP, SX, SZ, 0, 1, 4'd7);
    checks++; if (bus.done_valid !== 1'b1) begin errors++; $display("FAIL nop_done: got %b want 1", bus.done_valid); end
    checks++; if (bus.result !== 4'h1) begin errors++; $display("FAIL nop_result: got %h want 1", bus.result); end
    checks++; if ({bus.flag_c, bus.flag_z} !== 2'b10) begin errors++; $display("FAIL nop_flags: got %b want 10", {bus.flag_c, bus.flag_z}); end
    bus.rd_idx = 0; #1;
    checks++; if (bus.rd_data !== 4'h9) begin errors++; $display("FAIL nop_reg0: got %h want 9", bus.rd_data); end
    bus.rd_idx = 1; #1;
    checks++; if (bus.rd_data !== 4'h1) begin errors++; $display("FAIL nop_reg1: got %h want 1", bus.rd_data); end
    cmd(OP_ADD, SX, SZ, 0, 0, 4'd2);
    checks++; if ({bus.result, bus.flag_c} !== 5'b0010_0) begin errors++; $display("FAIL nowr_result_c: got %h/%b want 2/0", bus.result, bus.flag_c); end
    bus.rd_idx = 0; #1;
    checks++; if (bus.rd_data !== 4'h9) begin errors++; $display("FAIL nowr_reg0: got %h want 9", bus.rd_data); end
  endtask
  task automatic test_logic;
    cmd(OP_AND, SR0, SX, 1, 0, 4'hC);
    checks++; if (bus.result !== 4'h8) begin errors++; $display("FAIL and_result: got %h want 8", bus.result); end
    cmd(OP_OR, SR0, SX, 1, 0, 4'hC);
    checks++; if (bus.result !== 4'hD) begin errors++; $display("FAIL or_result: got %h want d", bus.result); end
    cmd(OP_XOR, SR0, SX, 1, 0, 4'hC);
    checks++; if (bus.result !== 4'h5) begin errors++; $display("FAIL xor_result: got %h want 5", bus.result); end
    cmd(OP_XOR, SR0, SR0, 1, 0, 4'hC);
    checks++; if ({bus.flag_c, bus.flag_z} !== 2'b01) begin errors++; $display("FAIL xor_zero_flags: got %b want 01", {bus.flag_c, bus.flag_z}); end
  endtask
  initial begin
    test_reset;
    test_add_basic;
    test_back_to_back;
    test_sub;
    test_mul;
    test_mul_reset;
    test_nop_wr_en;
    test_logic;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
